// File: rtl/ift_sram_pkg.sv
// Shared types and constants for the taint-tracking pipelined SRAM.
package ift_sram_pkg;

    // Deepest read pipeline supported; larger Latency values are clamped to this.
    localparam int unsigned MaxLatency = 8;

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StScrub
    } sram_state_e;

    // Clamp a requested read latency into the supported 1..MaxLatency range.
    function automatic int unsigned clamp_latency(input int unsigned lat);
        if (lat < 1) begin
            return 1;
        end else if (lat > MaxLatency) begin
            return MaxLatency;
        end
        return lat;
    endfunction

endpackage

// File: rtl/ift_sram_rsp_pipe.sv
// Fixed-depth valid/payload shift register carrying read responses and their taint.
module ift_sram_rsp_pipe #(
    parameter int unsigned Depth = 1,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o
);

    logic [Depth-1:0] vld_q;
    logic [Width-1:0] pay_q [Depth];

    // Shift valid and payload one stage per cycle; reset empties every stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                pay_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= valid_i;
            pay_q[0] <= data_i;
            for (int i = 1; i < int'(Depth); i++) begin
                vld_q[i] <= vld_q[i-1];
                pay_q[i] <= pay_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[Depth-1];
    assign data_o  = pay_q[Depth-1];

endmodule

// File: rtl/ift_sram_pipelined.sv
// Single-port SRAM with per-bit, multi-channel taint tracking, configurable read
// latency and a scrub engine that clears the taint array and sticky full-memory flags.
module ift_sram_pipelined #(
    parameter int unsigned NumWords   = 1024,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned ByteWidth  = 8,
    parameter int unsigned Latency    = 1,
    parameter int unsigned NumTaints  = 2,
    parameter bit          AutoScrub  = 1'b1,
    parameter int unsigned AddrWidth  = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int unsigned WidthBytes = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 req_i,
    output logic                                 gnt_o,
    input  logic                                 we_i,
    input  logic [AddrWidth-1:0]                 addr_i,
    input  logic [DataWidth-1:0]                 wdata_i,
    input  logic [WidthBytes-1:0]                be_i,
    output logic                                 rvalid_o,
    output logic [DataWidth-1:0]                 rdata_o,
    input  logic                                 scrub_i,
    output logic                                 busy_o,
    input  logic [NumTaints-1:0]                 clk_i_t0,
    input  logic [NumTaints-1:0]                 rst_ni_t0,
    input  logic [NumTaints-1:0]                 req_i_t0,
    input  logic [NumTaints-1:0]                 we_i_t0,
    input  logic [NumTaints-1:0][AddrWidth-1:0]  addr_i_t0,
    input  logic [NumTaints-1:0][DataWidth-1:0]  wdata_i_t0,
    input  logic [NumTaints-1:0][WidthBytes-1:0] be_i_t0,
    output logic [NumTaints-1:0]                 rvalid_o_t0,
    output logic [NumTaints-1:0][DataWidth-1:0]  rdata_o_t0,
    output logic [NumTaints-1:0]                 full_taint_o
);

    import ift_sram_pkg::*;

    localparam int unsigned PipeDepth = clamp_latency(Latency);
    localparam int unsigned PayWidth  = 1 + NumTaints + NumTaints * DataWidth + DataWidth;
    localparam logic [AddrWidth-1:0] LastWord = AddrWidth'(NumWords - 1);

    sram_state_e          state_q;
    logic [AddrWidth-1:0] cnt_q;
    logic                 gnt_q;
    logic                 busy_q;
    logic [NumTaints-1:0] sticky_q, sticky_d;

    logic [DataWidth-1:0]                mem_q  [NumWords];
    logic [NumTaints-1:0][DataWidth-1:0] tmem_q [NumWords];

    logic                                 acc;
    logic                                 in_range;
    logic                                 scrub_last;
    logic [NumTaints-1:0]                 addr_tnt;
    logic [NumTaints-1:0]                 wr_maybe;
    logic [NumTaints-1:0]                 ctrl_tnt;
    logic [NumTaints-1:0]                 ghost_req;
    logic [WidthBytes-1:0]                wr_lane;
    logic [NumTaints-1:0][WidthBytes-1:0] ones_lane;
    logic [DataWidth-1:0]                 rd_data;
    logic [NumTaints-1:0][DataWidth-1:0]  rd_taint;

    logic                                 rsp_vld;
    logic [PayWidth-1:0]                  pay_in, pay_out;
    logic                                 rsp_rd;
    logic [NumTaints-1:0]                 rsp_rvt;
    logic [NumTaints-1:0][DataWidth-1:0]  rsp_taint;
    logic [DataWidth-1:0]                 rsp_data;

    // Clock and reset taints carry no information flow into this model.
    logic unused_taint;
    assign unused_taint = ^{clk_i_t0, rst_ni_t0};

    assign acc        = req_i & gnt_q;
    assign in_range   = (32'(addr_i) < NumWords);
    assign scrub_last = (state_q == StScrub) && (cnt_q == LastWord);
    assign gnt_o      = gnt_q;
    assign busy_o     = busy_q;

    // Control FSM: init, idle (granting), scrub (walking the taint array).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StInit;
            cnt_q   <= '0;
            gnt_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StInit: begin
                    cnt_q <= '0;
                    if (AutoScrub) begin
                        state_q <= StScrub;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                        gnt_q   <= 1'b1;
                    end
                end
                StIdle: begin
                    if (scrub_i) begin
                        state_q <= StScrub;
                        gnt_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                StScrub: begin
                    if (cnt_q == LastWord) begin
                        state_q <= StIdle;
                        gnt_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    // Per-channel write masks and sticky-flag next state.
    always_comb begin
        sticky_d  = sticky_q;
        wr_lane   = (acc && we_i && in_range) ? be_i : '0;
        ones_lane = '0;
        for (int c = 0; c < int'(NumTaints); c++) begin
            addr_tnt[c]  = |addr_i_t0[c];
            wr_maybe[c]  = we_i | we_i_t0[c];
            ctrl_tnt[c]  = addr_tnt[c] | req_i_t0[c] | we_i_t0[c];
            // A tainted request line may have hidden a real access.
            ghost_req[c] = !req_i && gnt_q && req_i_t0[c] && wr_maybe[c];
            if (acc && in_range) begin
                if (we_i_t0[c]) begin
                    ones_lane[c] = be_i | be_i_t0[c];
                end
                if (wr_maybe[c]) begin
                    ones_lane[c] = ones_lane[c] | (be_i_t0[c] & ~be_i);
                end
            end
            if (ghost_req[c] && !addr_tnt[c] && in_range) begin
                ones_lane[c] = '1;
            end
            // A write through a tainted address could have landed anywhere.
            if (acc && wr_maybe[c] && addr_tnt[c] && (|(be_i | be_i_t0[c]))) begin
                sticky_d[c] = 1'b1;
            end
            if (ghost_req[c] && addr_tnt[c]) begin
                sticky_d[c] = 1'b1;
            end
        end
        if (scrub_last) begin
            sticky_d = '0;
        end
    end

    // Sticky full-memory taint flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    // Data and taint arrays; the scrub walker zeroes one taint word per cycle.
    always_ff @(posedge clk_i) begin
        if (state_q == StScrub) begin
            tmem_q[cnt_q] <= '0;
        end
        for (int b = 0; b < int'(WidthBytes); b++) begin
            if (wr_lane[b]) begin
                mem_q[addr_i][b*ByteWidth +: ByteWidth] <= wdata_i[b*ByteWidth +: ByteWidth];
            end
            for (int c = 0; c < int'(NumTaints); c++) begin
                if (ones_lane[c][b]) begin
                    tmem_q[addr_i][c][b*ByteWidth +: ByteWidth] <= '1;
                end else if (wr_lane[b]) begin
                    tmem_q[addr_i][c][b*ByteWidth +: ByteWidth] <=
                        wdata_i_t0[c][b*ByteWidth +: ByteWidth];
                end
            end
        end
    end

    // Read payload sampled at acceptance; write responses carry zero data.
    always_comb begin
        rd_data  = (!we_i && in_range) ? mem_q[addr_i] : '0;
        rd_taint = '0;
        for (int c = 0; c < int'(NumTaints); c++) begin
            if (!we_i && in_range) begin
                rd_taint[c] = tmem_q[addr_i][c];
            end
            rd_taint[c] = rd_taint[c] | {DataWidth{ctrl_tnt[c]}};
        end
    end

    assign pay_in = {~we_i, req_i_t0, rd_taint, rd_data};

    ift_sram_rsp_pipe #(
        .Depth (PipeDepth),
        .Width (PayWidth)
    ) u_rsp_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (acc),
        .data_i  (pay_in),
        .valid_o (rsp_vld),
        .data_o  (pay_out)
    );

    assign {rsp_rd, rsp_rvt, rsp_taint, rsp_data} = pay_out;

    // Response outputs; the sticky flag is folded in at response time for reads.
    always_comb begin
        rvalid_o    = rsp_vld;
        rdata_o     = rsp_vld ? rsp_data : '0;
        rvalid_o_t0 = rsp_vld ? rsp_rvt : '0;
        rdata_o_t0  = '0;
        for (int c = 0; c < int'(NumTaints); c++) begin
            if (rsp_vld) begin
                rdata_o_t0[c] = rsp_taint[c] | {DataWidth{rsp_rd & sticky_q[c]}};
            end
        end
    end

    assign full_taint_o = sticky_q;

endmodule
